// File: rtl/dl_report_arbiter_if.sv
// Connection bundle between the per-process deadlock detect units and the report arbiter.
// The dbg_* signals expose arbiter internals for checkers and carry no functional meaning.
interface dl_report_arbiter_if #(
   parameter int PROC_NUM = 2
);
   localparam int IW = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;

   // Level signalling only: no valid/ready handshake. dl_in_vec is sampled on every
   // rising clock edge. token_clear and report_valid are single-cycle pulses that
   // receivers must accept unconditionally, because nothing can stall them.
   logic [PROC_NUM-1:0] dl_in_vec;
   logic                dl_detect_out;
   logic [PROC_NUM-1:0] origin;
   logic                token_clear;
   logic                report_valid;
   logic [IW-1:0]       report_index;
   logic [1:0]          dbg_state;
   logic [IW-1:0]       dbg_rr_ptr;
   logic [7:0]          dbg_conf_cnt;

   modport master (
      output dl_in_vec,
      input  dl_detect_out, origin, token_clear, report_valid, report_index,
      input  dbg_state, dbg_rr_ptr, dbg_conf_cnt
   );

   modport slave (
      input  dl_in_vec,
      output dl_detect_out, origin, token_clear, report_valid, report_index,
      output dbg_state, dbg_rr_ptr, dbg_conf_cnt
   );
endinterface

// File: rtl/dl_report_arbiter.sv
// Round-robin arbiter that picks one deadlock suspect and confirms it over CONFIRM_CYCLES cycles.
// A confirmed suspect is reported once and latched until reset. A rejected suspect clears the tokens.
module dl_report_arbiter #(
   parameter int PROC_NUM       = 2,
   parameter int CONFIRM_CYCLES = 4
) (
   input  logic              clock,
   input  logic              reset,
   dl_report_arbiter_if.slave arb
);
   localparam int IW = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
   localparam logic [7:0] CNT_LAST = 8'(CONFIRM_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONFIRM = 2'd1,
      CLEAR   = 2'd2,
      REPORT  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [PROC_NUM-1:0] origin_q, origin_d;
   logic [IW-1:0]       origin_idx_q, origin_idx_d;
   logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [7:0]          conf_cnt_q, conf_cnt_d;
   logic                dl_detect_q, dl_detect_d;
   logic                token_clear_q, token_clear_d;
   logic                report_valid_q, report_valid_d;
   logic [IW-1:0]       report_index_q, report_index_d;

   logic                pick_found;
   logic [IW-1:0]       pick_idx;
   logic [IW-1:0]       scan_idx;
   logic                origin_bit;

   // First set bit, searching upward from rr_ptr and wrapping at PROC_NUM.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int k = 0; k < PROC_NUM; k++) begin
         scan_idx = IW'((int'(rr_ptr_q) + k) % PROC_NUM);
         if (!pick_found && arb.dl_in_vec[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   assign origin_bit = arb.dl_in_vec[origin_idx_q];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_found) state_d = CONFIRM;
         CONFIRM: begin
            if (!origin_bit)                state_d = CLEAR;
            else if (conf_cnt_q == CNT_LAST) state_d = REPORT;
         end
         CLEAR:   state_d = IDLE;
         REPORT:  state_d = REPORT;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath. Anything not assigned here holds.
   always_comb begin
      origin_d       = origin_q;
      origin_idx_d   = origin_idx_q;
      rr_ptr_d       = rr_ptr_q;
      conf_cnt_d     = conf_cnt_q;
      dl_detect_d    = dl_detect_q;
      token_clear_d  = 1'b0;
      report_valid_d = 1'b0;
      report_index_d = report_index_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               origin_d     = PROC_NUM'(1) << pick_idx;
               origin_idx_d = pick_idx;
               conf_cnt_d   = 8'd0;
            end
         end
         CONFIRM: begin
            if (origin_bit) begin
               if (conf_cnt_q != 8'hFF) conf_cnt_d = conf_cnt_q + 8'd1;
               if (conf_cnt_q == CNT_LAST) begin
                  dl_detect_d    = 1'b1;
                  report_valid_d = 1'b1;
                  report_index_d = origin_idx_q;
               end
            end else begin
               token_clear_d = 1'b1;
               origin_d      = '0;
               rr_ptr_d      = (origin_idx_q == IW'(PROC_NUM - 1)) ? '0 : origin_idx_q + IW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         origin_q       <= '0;
         origin_idx_q   <= '0;
         rr_ptr_q       <= '0;
         conf_cnt_q     <= 8'd0;
         dl_detect_q    <= 1'b0;
         token_clear_q  <= 1'b0;
         report_valid_q <= 1'b0;
         report_index_q <= '0;
      end else begin
         origin_q       <= origin_d;
         origin_idx_q   <= origin_idx_d;
         rr_ptr_q       <= rr_ptr_d;
         conf_cnt_q     <= conf_cnt_d;
         dl_detect_q    <= dl_detect_d;
         token_clear_q  <= token_clear_d;
         report_valid_q <= report_valid_d;
         report_index_q <= report_index_d;
      end
   end

   assign arb.dl_detect_out = dl_detect_q;
   assign arb.origin        = origin_q;
   assign arb.token_clear   = token_clear_q;
   assign arb.report_valid  = report_valid_q;
   assign arb.report_index  = report_index_q;
   assign arb.dbg_state     = state_q;
   assign arb.dbg_rr_ptr    = rr_ptr_q;
   assign arb.dbg_conf_cnt  = conf_cnt_q;
endmodule

// File: doc/dl_report_arbiter.md
DL_REPORT_ARBITER -- requirements
Module: dl_report_arbiter

Interface
REQ-001 The block SHALL have parameter PROC_NUM, default 2, giving the number of monitored processes (per-process detect units); legal range 2..64.
REQ-002 The block SHALL have parameter CONFIRM_CYCLES, default 4, giving the consecutive cycles a candidate deadlock bit must stay high before report; legal range 1..255.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port clock, input, 1 bit: all state updates on its rising edge.
REQ-005 The block SHALL have port dl_in_vec, input, PROC_NUM bits: per-process deadlock-suspect flags from the detect units.
REQ-006 The block SHALL have port dl_detect_out, output, 1 bit: sticky confirmed-deadlock flag, broadcast back to all detect units.
REQ-007 The block SHALL have port origin, output, PROC_NUM bits: one-hot marker of the process currently arbitrated or reported; all-zero when none.
REQ-008 The block SHALL have port token_clear, output, 1 bit: one-cycle pulse telling detect units to discard circulating tokens after a rejected candidate.
REQ-009 The block SHALL have port report_valid, output, 1 bit: one-cycle pulse on deadlock confirmation.
REQ-010 The block SHALL have port report_index, output, clog2(PROC_NUM) bits: binary index of the origin, valid when report_valid is high and held afterwards.

Function
REQ-011 The block SHALL implement states IDLE, CONFIRM, CLEAR, REPORT, encoded in a registered state variable.
REQ-012 IDLE: when dl_in_vec is non-zero, the block SHALL, on the next edge, load origin with the one-hot of the first set bit searched round-robin from rr_ptr upward (wrapping), clear conf_cnt, and enter CONFIRM.
REQ-013 CONFIRM: each cycle the origin bit of dl_in_vec is high, conf_cnt SHALL increment; when it is high and conf_cnt equals CONFIRM_CYCLES-1, the next state SHALL be REPORT.
REQ-014 CONFIRM: if the origin bit of dl_in_vec is low in any cycle, the block SHALL enter CLEAR on the next edge, driving token_clear=1 and origin=0 for exactly that CLEAR cycle.
REQ-015 On rejection, rr_ptr SHALL be set to (rejected index + 1) mod PROC_NUM; rr_ptr SHALL be otherwise unchanged.
REQ-016 CLEAR SHALL last exactly one cycle and return to IDLE unconditionally; no arbitration SHALL occur in the CLEAR cycle.
REQ-017 On entry to REPORT, dl_detect_out SHALL rise to 1 and report_valid SHALL pulse for exactly one cycle; report_index SHALL equal the origin index.
REQ-018 REPORT SHALL be terminal: dl_detect_out, origin and report_index SHALL hold until reset regardless of dl_in_vec.
REQ-019 Bits of dl_in_vec other than the origin bit SHALL be ignored in CONFIRM, CLEAR and REPORT.
REQ-020 With CONFIRM_CYCLES=1, REPORT SHALL be entered on the edge after the first CONFIRM cycle in which the origin bit is high.
REQ-021 conf_cnt SHALL be 8 bits and SHALL never wrap; it is not incremented outside CONFIRM.
REQ-022 If multiple bits are set in IDLE, exactly one SHALL be selected per REQ-012; origin SHALL never have more than one bit set.

Reset
REQ-023 Reset low SHALL asynchronously force state=IDLE, dl_detect_out=0, origin=0, token_clear=0, report_valid=0, report_index=0, rr_ptr=0, conf_cnt=0, including mid-CONFIRM and in REPORT.
REQ-024 After reset deasserts, the first arbitration SHALL occur no earlier than the first rising edge with reset high.

Verification (PROC_NUM=2, CONFIRM_CYCLES=4)
REQ-025 Steady suspect: dl_in_vec=2'b01 held from cycle 0 -> origin=2'b01 at cycle 1; dl_detect_out=1, report_valid pulse, report_index=0 at cycle 5; all held at cycle 20.
REQ-026 Transient: dl_in_vec=2'b10 for 2 cycles then 0 -> origin=2'b10, then token_clear=1 one cycle with origin=0, back to IDLE; dl_detect_out stays 0; rr_ptr=0.
REQ-027 Round-robin: dl_in_vec=2'b11 in cycles where bit0 drops once during CONFIRM, then both held -> second arbitration selects origin=2'b10, report_index=1.
REQ-028 Simultaneous: dl_in_vec=2'b11 from reset, rr_ptr=0 -> origin=2'b01 only; report_index=0 after 4 confirm cycles.
REQ-029 Reset mid-operation: assert reset in CONFIRM cycle 2 and again in REPORT -> all outputs 0 immediately (asynchronously), no report_valid pulse.
REQ-030 Sticky: after REPORT, drive dl_in_vec=0 for 10 cycles -> dl_detect_out=1, origin unchanged, token_clear=0, report_valid=0 throughout.
